// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: FSM states, out_sel bit positions,
// in_sel operand-control codes and a one-hot test helper.
package alu_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    READY = 2'b01,
    BUSY  = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam int OP_ADD = 6;
  localparam int OP_SUB = 5;
  localparam int OP_MUL = 4;
  localparam int OP_AND = 3;
  localparam int OP_OR  = 2;
  localparam int OP_XOR = 1;
  localparam int OP_NOT = 0;

  localparam logic [2:0] SEL_HOLD  = 3'b100;
  localparam logic [2:0] SEL_LOAD  = 3'b010;
  localparam logic [2:0] SEL_CLEAR = 3'b001;
  localparam logic [2:0] SEL_ACCUM = 3'b110;

  function automatic logic is_onehot(input logic [6:0] v);
    return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: the first partial product is taken on start,
// the remaining WIDTH-1 on following cycles, so a product takes WIDTH cycles.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // cnt counts partial products taken; reaching WIDTH means idle/complete
  always_ff @(posedge clk) begin
    if (rst) begin
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= LAST;
    end else if (start) begin
      prod   <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier <= b >> 1;
      cnt    <= CW'(1);
    end else if (abort) begin
      cnt <= LAST;
    end else if (busy) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  assign busy = (cnt != LAST);

endmodule

// File: rtl/alu_seq_core.sv
// Sequential ALU with registered operands, one-hot op select and done/err handshake.
// Define ALU_ACCUM_EN to make in_sel=110 load final1 from the previous result.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               on,
  input  logic [2:0]         in_sel,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
  input  logic [NUM_OPS-1:0] out_sel,
  output logic [WIDTH-1:0]   final1,
  output logic [WIDTH-1:0]   final2,
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   out_hi,
  output logic               carry,
  output logic               ovf,
  output logic               zero,
  output logic               done,
  output logic               err,
  output logic [1:0]         currState,
  output logic [1:0]         nextState
);

  if (NUM_OPS != 7 || WIDTH < 2) begin : g_param_check
    $error("alu_seq_core: NUM_OPS must be 7 and WIDTH at least 2");
  end

  state_t               state, next;
  logic [NUM_OPS-1:0]   op;
  logic [WIDTH-1:0]     op_a, op_b;
  logic                 sel_ok, issue, mul_busy;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH:0]       sum, diff;
  logic [WIDTH-1:0]     res;
  logic                 res_c, res_v;

  assign sel_ok = is_onehot(out_sel);
  assign issue  = (state == READY) && on && sel_ok;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (issue && out_sel[OP_MUL]),
    .abort (~on),
    .a     (final1),
    .b     (final2),
    .prod  (prod),
    .busy  (mul_busy)
  );

  always_comb begin
    next = state;
    case (state)
      OFF:   if (on) next = READY;
      READY: if (!on) next = OFF; else if (sel_ok) next = BUSY;
      BUSY:  if (!on) next = OFF; else if (!op[OP_MUL] || !mul_busy) next = DONE;
      DONE:  next = on ? READY : OFF;
    endcase
  end

  // Single-cycle ops work on the operand snapshot taken at issue
  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    if (op[OP_ADD]) begin
      res   = sum[WIDTH-1:0];
      res_c = sum[WIDTH];
      res_v = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
    end else if (op[OP_SUB]) begin
      res   = diff[WIDTH-1:0];
      res_c = diff[WIDTH];
      res_v = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
    end else if (op[OP_AND]) begin
      res = op_a & op_b;
    end else if (op[OP_OR]) begin
      res = op_a | op_b;
    end else if (op[OP_XOR]) begin
      res = op_a ^ op_b;
    end else if (op[OP_NOT]) begin
      res = ~op_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= OFF;
      op     <= '0;
      op_a   <= '0;
      op_b   <= '0;
      final1 <= '0;
      final2 <= '0;
      out    <= '0;
      out_hi <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= next;
      done  <= 1'b0;
      err   <= (state == READY) && on && !sel_ok;
      if (issue) begin
        op   <= out_sel;
        op_a <= final1;
        op_b <= final2;
      end
      // Operands are frozen while a computation is in flight
      if (state != BUSY) begin
        case (in_sel)
          SEL_HOLD: ;
          SEL_LOAD: begin
            final1 <= num1;
            final2 <= num2;
          end
          SEL_CLEAR: begin
            final1 <= '0;
            final2 <= '0;
          end
`ifdef ALU_ACCUM_EN
          SEL_ACCUM: begin
            final1 <= out;
            final2 <= num2;
          end
`else
          SEL_ACCUM: ;
`endif
          default: ;
        endcase
      end
      if (state == BUSY && next == DONE) begin
        done <= 1'b1;
        if (op[OP_MUL]) begin
          out    <= prod[WIDTH-1:0];
          out_hi <= prod[2*WIDTH-1:WIDTH];
          carry  <= 1'b0;
          ovf    <= 1'b0;
          zero   <= (prod == '0);
        end else begin
          out    <= res;
          out_hi <= '0;
          carry  <= res_c;
          ovf    <= res_v;
          zero   <= (res == '0);
        end
      end
    end
  end

  assign currState = state;
  assign nextState = next;

endmodule

// File: tb/tb_alu_seq_core.sv
// Randomized self-checking bench for alu_seq_core against an arithmetic reference model.
// Honours ALU_ACCUM_EN the same way as the design.
module tb_alu_seq_core;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, on;
  logic [2:0]   in_sel;
  logic [W-1:0] num1, num2;
  logic [6:0]   out_sel;
  logic [W-1:0] final1, final2, out, out_hi;
  logic         carry, ovf, zero, done, err;
  logic [1:0]   currState, nextState;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_f1 = '0, m_f2 = '0, m_out = '0, m_hi = '0;
  logic         m_c = 1'b0, m_v = 1'b0, m_z = 1'b0;

  alu_seq_core #(.WIDTH(W), .NUM_OPS(7)) dut (
    .clk(clk), .rst(rst), .on(on), .in_sel(in_sel), .num1(num1), .num2(num2),
    .out_sel(out_sel), .final1(final1), .final2(final2), .out(out), .out_hi(out_hi),
    .carry(carry), .ovf(ovf), .zero(zero), .done(done), .err(err),
    .currState(currState), .nextState(nextState)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic o, input logic [2:0] s, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [6:0] sel);
    on      = o;
    in_sel  = s;
    num1    = a;
    num2    = b;
    out_sel = sel;
  endtask

  // Operand register effect of in_sel when the ALU is not computing
  task automatic modelInSel(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    case (s)
      3'b010: begin m_f1 = a; m_f2 = b; end
      3'b001: begin m_f1 = '0; m_f2 = '0; end
`ifdef ALU_ACCUM_EN
      3'b110: begin m_f1 = m_out; m_f2 = b; end
`endif
      default: ;
    endcase
  endtask

  // Result of op index idx (6=ADD .. 0=NOT) from plain integer arithmetic
  task automatic modelOp(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] e_out, output logic [W-1:0] e_hi,
                         output logic e_c, output logic e_v, output logic e_z);
    int ua, ub, sa, sb, r, sr;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    r = 0; sr = 0; e_hi = '0; e_c = 1'b0; e_v = 1'b0;
    case (idx)
      6: begin
        r = ua + ub; sr = sa + sb;
        e_c = (r >= (1 << W));
        e_v = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
      end
      5: begin
        r = ua - ub; sr = sa - sb;
        e_c = (ua < ub);
        e_v = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
      end
      4: begin
        r = ua * ub;
        e_hi = W'(r >> W);
      end
      3: r = ua & ub;
      2: r = ua | ub;
      1: r = ua ^ ub;
      default: r = ~ua;
    endcase
    e_out = W'(r);
    e_z = (e_out == '0) && (e_hi == '0);
  endtask

  // Issue from READY, run through BUSY with loads attempted every cycle, check the DONE cycle
  task automatic runOp(input int idx, input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] e_out, e_hi;
    logic e_c, e_v, e_z;
    int lat, early;
    modelOp(idx, m_f1, m_f2, e_out, e_hi, e_c, e_v, e_z);
    applyStimulus(1'b1, s, a, b, 7'(1 << idx));
    modelInSel(s, a, b);
    tick;
    checkOutput("issue_state", currState, 2);
    checkOutput("issue_err", err, 0);
    lat = (idx == 4) ? W : 1;
    early = 0;
    for (int i = 1; i <= lat; i++) begin
      applyStimulus(1'b1, 3'b010, W'($urandom), W'($urandom), 7'b0);
      tick;
      if (i < lat && done) early++;
    end
    checkOutput("early_done", early, 0);
    checkOutput("done", done, 1);
    checkOutput("done_state", currState, 3);
    checkOutput("done_next", nextState, 1);
    checkOutput("out", out, e_out);
    checkOutput("out_hi", out_hi, e_hi);
    checkOutput("flags", {carry, ovf, zero}, {e_c, e_v, e_z});
    checkOutput("busy_final1", final1, m_f1);
    checkOutput("busy_final2", final2, m_f2);
    m_out = e_out; m_hi = e_hi; m_c = e_c; m_v = e_v; m_z = e_z;
  endtask

  // Leave DONE with the given in_sel; on=0 drops to OFF and then comes back up
  task automatic finishDone(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b, input logic o);
    applyStimulus(o, s, a, b, 7'b0);
    modelInSel(s, a, b);
    tick;
    checkOutput("after_done_state", currState, o ? 2'd1 : 2'd0);
    checkOutput("after_done_pulse", done, 0);
    checkOutput("after_done_final1", final1, m_f1);
    checkOutput("after_done_final2", final2, m_f2);
    if (!o) begin
      s = 3'($urandom);
      a = W'($urandom);
      b = W'($urandom);
      applyStimulus(1'b1, s, a, b, 7'b0);
      modelInSel(s, a, b);
      tick;
      checkOutput("wake_state", currState, 1);
      checkOutput("wake_final1", final1, m_f1);
    end
  endtask

  initial begin
    int early;
    logic [6:0] sel;
    logic [2:0] s;
    logic [W-1:0] a, b;
    int i, j;

    rst = 1'b1;
    applyStimulus(1'b0, 3'b100, '0, '0, 7'b0);
    tick;
    tick;
    checkOutput("reset_state", currState, 0);
    checkOutput("reset_outs", {out, out_hi, final1, final2, carry, ovf, zero, done, err}, 0);

    rst = 1'b0;
    applyStimulus(1'b1, 3'b010, 8'h57, 8'h1A, 7'b0);
    modelInSel(3'b010, 8'h57, 8'h1A);
    tick;
    checkOutput("release_state", currState, 1);

    runOp(6, 3'b100, '0, '0);
    checkOutput("add_57_1a", {out, carry, ovf}, {8'h71, 1'b0, 1'b0});

    finishDone(3'b010, 8'h02, 8'h04, 1'b1);
    runOp(5, 3'b100, '0, '0);
    checkOutput("sub_02_04", {out, carry, ovf, zero}, {8'hFE, 1'b1, 1'b0, 1'b0});

    finishDone(3'b010, 8'hFF, 8'h01, 1'b1);
    runOp(6, 3'b100, '0, '0);
    checkOutput("add_ff_01", {out, carry, zero}, {8'h00, 1'b1, 1'b1});

    finishDone(3'b010, 8'h57, 8'h1A, 1'b1);
    runOp(4, 3'b100, '0, '0);
    checkOutput("mul_57_1a", {out_hi, out}, 16'h08D6);

    // MUL aborted by dropping on in its third BUSY cycle
    finishDone(3'b100, '0, '0, 1'b1);
    applyStimulus(1'b1, 3'b100, '0, '0, 7'b0010000);
    tick;
    early = 0;
    applyStimulus(1'b1, 3'b010, 8'h11, 8'h22, 7'b0);
    tick;
    if (done) early++;
    tick;
    if (done) early++;
    checkOutput("abort_busy_state", currState, 2);
    applyStimulus(1'b0, 3'b100, '0, '0, 7'b0);
    tick;
    if (done) early++;
    checkOutput("abort_state", currState, 0);
    checkOutput("abort_no_done", early, 0);
    checkOutput("abort_out_kept", {out_hi, out}, {m_hi, m_out});
    checkOutput("abort_final1", final1, m_f1);
    applyStimulus(1'b1, 3'b100, '0, '0, 7'b0);
    tick;
    checkOutput("abort_wake", currState, 1);

    applyStimulus(1'b1, 3'b100, '0, '0, 7'b0000011);
    tick;
    checkOutput("multihot_err", err, 1);
    checkOutput("multihot_state", currState, 1);

    runOp(6, 3'b100, '0, '0);
    checkOutput("chain_first", out, 8'h71);
    finishDone(3'b110, 8'h33, 8'h0F, 1'b1);
`ifdef ALU_ACCUM_EN
    checkOutput("accum_final1", final1, 8'h71);
    checkOutput("accum_final2", final2, 8'h0F);
    runOp(6, 3'b100, '0, '0);
    checkOutput("accum_add", {out, carry, ovf}, {8'h80, 1'b0, 1'b1});
    finishDone(3'b100, '0, '0, 1'b1);
`else
    checkOutput("hold110_final1", final1, 8'h57);
    checkOutput("hold110_final2", final2, 8'h1A);
`endif

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        i = $urandom_range(0, 6);
        j = (i + 1 + $urandom_range(0, 5)) % 7;
        sel = ($urandom_range(0, 1) == 0) ? 7'b0 : 7'((1 << i) | (1 << j));
        s = 3'($urandom);
        a = W'($urandom);
        b = W'($urandom);
        applyStimulus(1'b1, s, a, b, sel);
        modelInSel(s, a, b);
        tick;
        checkOutput("rand_err", err, 1);
        checkOutput("rand_err_state", currState, 1);
      end
      runOp($urandom_range(0, 6), 3'($urandom), W'($urandom), W'($urandom));
      finishDone(3'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
